// File: rtl/serializador_if.sv
// rtl/serializador_if.sv - queue-side and link-side signals of the serializador.
interface serializador_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_valid_in;
    logic                  hold_in;
    logic                  ack_out;
    logic                  data_out;
    logic                  write_out;
    logic                  busy_out;

    modport master (
        output data_in, data_valid_in, hold_in,
        input  ack_out, data_out, write_out, busy_out
    );

    modport slave (
        input  data_in, data_valid_in, hold_in,
        output ack_out, data_out, write_out, busy_out
    );
endinterface

// File: rtl/serializador.sv
// rtl/serializador.sv - parallel-to-serial transmitter with write strobe and inter-word gap.
// Optional even-parity trailer bit enabled by defining SERIALIZADOR_PARITY_EN.
module serializador #(
    parameter int DATA_WIDTH = 8,
    parameter int GAP_CYCLES = 1,
    parameter int MSB_FIRST  = 1
) (
    input  logic           clk_100KHz,
    input  logic           reset,
    serializador_if.slave  link
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_PARITY,
        S_GAP
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  ack_q, ack_d;
    logic                  data_q, data_d;
    logic                  write_q, write_d;
    logic                  busy_q, busy_d;
    logic                  word_done;
`ifdef SERIALIZADOR_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    // The shift register always presents the next bit to send at its leading end.
    function automatic logic lead_bit(input logic [DATA_WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[DATA_WIDTH-1] : w[0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
    endfunction

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        shreg_d   = shreg_q;
        ack_d     = 1'b0;
        data_d    = 1'b0;
        write_d   = 1'b0;
        busy_d    = 1'b0;
        word_done = 1'b0;
`ifdef SERIALIZADOR_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (link.data_valid_in && !link.hold_in) begin
                    state_d   = S_SHIFT;
                    bit_cnt_d = '0;
                    shreg_d   = advance(link.data_in);
                    data_d    = lead_bit(link.data_in);
                    ack_d     = 1'b1;
                    write_d   = 1'b1;
                    busy_d    = 1'b1;
`ifdef SERIALIZADOR_PARITY_EN
                    parity_d  = ^link.data_in;
`endif
                end
            end
            S_SHIFT: begin
                if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
`ifdef SERIALIZADOR_PARITY_EN
                    state_d = S_PARITY;
                    data_d  = parity_q;
                    write_d = 1'b1;
                    busy_d  = 1'b1;
`else
                    word_done = 1'b1;
`endif
                end else begin
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    shreg_d   = advance(shreg_q);
                    data_d    = lead_bit(shreg_q);
                    write_d   = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            S_PARITY: begin
                word_done = 1'b1;
            end
            S_GAP: begin
                if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                    busy_d    = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // With no gap configured the word ends straight into a one-cycle idle.
        if (word_done) begin
            if (GAP_CYCLES > 0) begin
                state_d   = S_GAP;
                gap_cnt_d = '0;
                busy_d    = 1'b1;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk_100KHz) begin
        if (reset) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            shreg_q   <= '0;
            ack_q     <= 1'b0;
            data_q    <= 1'b0;
            write_q   <= 1'b0;
            busy_q    <= 1'b0;
`ifdef SERIALIZADOR_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            shreg_q   <= shreg_d;
            ack_q     <= ack_d;
            data_q    <= data_d;
            write_q   <= write_d;
            busy_q    <= busy_d;
`ifdef SERIALIZADOR_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign link.ack_out   = ack_q;
    assign link.data_out  = data_q;
    assign link.write_out = write_q;
    assign link.busy_out  = busy_q;
endmodule

// File: tb/tb_serializador.sv
// tb/tb_serializador.sv - randomized and directed bench for serializador against a position-indexed word model.
module tb_serializador;
    localparam int W   = 8;
    localparam int GAP = 1;
`ifdef SERIALIZADOR_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int PERIOD = W + PAR + GAP + 1;

    logic clk_100KHz = 1'b0;
    logic reset      = 1'b1;

    serializador_if #(.DATA_WIDTH(W)) link ();

    serializador #(
        .DATA_WIDTH (W),
        .GAP_CYCLES (GAP),
        .MSB_FIRST  (1)
    ) dut (
        .clk_100KHz (clk_100KHz),
        .reset      (reset),
        .link       (link)
    );

    always #5 clk_100KHz = ~clk_100KHz;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit started  = 1'b0;

    logic [W-1:0] fila[$];
    logic [W-1:0] model_done[$];
    logic [W-1:0] rx_q[$];

    // Model: pos = 0 idle, 1..W data bits, W+1 parity (if any), then gap cycles.
    int           pos = 0;
    logic [W-1:0] cur_word = '0;

    logic [W:0]   rx_sh = '0;
    int           rx_n = 0;
    logic [W-1:0] rx_word, last_rx = '0;
    logic         last_rx_par = 1'b0;

    int ack_count = 0, last_ack_cyc = 0, prev_ack_cyc = 0;
    int write_run = 0, last_write_run = 0, busy_run = 0, last_busy_run = 0;
    int low_run = 0, last_low_run = 0, write_cycles = 0;
    bit seen_write = 1'b0;
    logic e_ack, e_wr, e_d, e_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk_100KHz) begin
        if (pos == W + PAR) model_done.push_back(cur_word);
        if (reset) pos = 0;
        else if (pos == 0) begin
            if (link.data_valid_in && !link.hold_in) begin
                cur_word = link.data_in;
                pos = 1;
            end
        end else if (pos >= W + PAR + GAP) pos = 0;
        else pos = pos + 1;
        started = 1'b1;
    end

    always @(negedge clk_100KHz) begin
        if (started) begin
            e_ack  = (pos == 1);
            e_busy = (pos >= 1);
            e_wr   = (pos >= 1) && (pos <= W + PAR);
            e_d    = 1'b0;
            if (pos >= 1 && pos <= W) e_d = cur_word[W-pos];
            else if (PAR == 1 && pos == W + 1) e_d = ^cur_word;
            chk("ack_out",   link.ack_out,   e_ack);
            chk("write_out", link.write_out, e_wr);
            chk("data_out",  link.data_out,  e_d);
            chk("busy_out",  link.busy_out,  e_busy);

            if (link.write_out) begin
                rx_sh = {rx_sh[W-1:0], link.data_out};
                rx_n++;
                if (rx_n == W + PAR) begin
                    rx_word = (PAR == 1) ? rx_sh[W:1] : rx_sh[W-1:0];
`ifdef SERIALIZADOR_PARITY_EN
                    chk("rx_parity", rx_sh[0], ^rx_word);
`endif
                    last_rx_par = rx_sh[0];
                    last_rx = rx_word;
                    rx_q.push_back(rx_word);
                    rx_n = 0;
                end
            end
            if (reset) rx_n = 0;

            if (link.ack_out) begin
                prev_ack_cyc = last_ack_cyc;
                last_ack_cyc = cyc;
                ack_count++;
            end
            if (link.write_out) begin
                if (seen_write && low_run > 0) last_low_run = low_run;
                low_run = 0;
                write_run++;
                write_cycles++;
                seen_write = 1'b1;
            end else begin
                if (write_run > 0) last_write_run = write_run;
                write_run = 0;
                low_run++;
            end
            if (link.busy_out) busy_run++;
            else begin
                if (busy_run > 0) last_busy_run = busy_run;
                busy_run = 0;
            end
            cyc++;
        end
    end

    task automatic present();
        link.data_valid_in = (fila.size() > 0);
        link.data_in       = (fila.size() > 0) ? fila[0] : '0;
    endtask

    task automatic tick();
        @(posedge clk_100KHz);
        #1;
        if (link.ack_out && fila.size() > 0) void'(fila.pop_front());
        present();
    endtask

    task automatic wait_ack(input int maxc);
        for (int i = 0; i < maxc; i++) begin
            tick();
            if (link.ack_out) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_ack: actual=timeout expected=ack within %0d cycles", maxc);
    endtask

    task automatic wait_idle(input int maxc);
        for (int i = 0; i < maxc; i++) begin
            tick();
            if (fila.size() == 0 && !link.busy_out) begin
                tick();
                return;
            end
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_idle: actual=timeout expected=idle within %0d cycles", maxc);
    endtask

    int a0, r0, wc0;

    initial begin
        link.hold_in = 1'b0;
        present();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        chk("reset_ack",   link.ack_out,   1'b0);
        chk("reset_write", link.write_out, 1'b0);
        chk("reset_data",  link.data_out,  1'b0);
        chk("reset_busy",  link.busy_out,  1'b0);

        fila.push_back(8'hA5);
        present();
        wait_ack(5);
        wait_idle(40);
        chk("a5_rx_word",   last_rx, 8'hA5);
        chk("a5_model",     model_done[model_done.size()-1], 8'hA5);
        chk("a5_write_run", last_write_run, 8 + PAR);
        chk("a5_busy_run",  last_busy_run, 9 + PAR);
        chk("a5_acks",      ack_count, 1);
`ifdef SERIALIZADOR_PARITY_EN
        chk("a5_parity_bit", last_rx_par, 1'b0);
        fila.push_back(8'h07);
        present();
        wait_idle(40);
        chk("07_parity_bit", last_rx_par, 1'b1);
`endif

        a0 = ack_count;
        fila.push_back(8'h3C);
        fila.push_back(8'hFF);
        present();
        wait_idle(60);
        chk("pair_acks",      ack_count, a0 + 2);
        chk("pair_ack_space", last_ack_cyc - prev_ack_cyc, PERIOD);
        chk("pair_low_run",   last_low_run, GAP + 1);
        chk("pair_rx_first",  rx_q[rx_q.size()-2], 8'h3C);
        chk("pair_rx_second", rx_q[rx_q.size()-1], 8'hFF);

        a0 = ack_count;
        wc0 = write_cycles;
        link.hold_in = 1'b1;
        fila.push_back(8'h81);
        present();
        repeat (20) tick();
        chk("hold_no_ack",   ack_count, a0);
        chk("hold_no_write", write_cycles, wc0);
        link.hold_in = 1'b0;
        wait_ack(5);
        repeat (3) tick();
        link.hold_in = 1'b1;
        fila.push_back(8'h42);
        present();
        repeat (30) tick();
        chk("hold_mid_acks", ack_count, a0 + 1);
        chk("hold_mid_rx",   last_rx, 8'h81);
        chk("hold_mid_busy", link.busy_out, 1'b0);
        link.hold_in = 1'b0;
        wait_idle(40);
        chk("hold_release_rx",   last_rx, 8'h42);
        chk("hold_release_acks", ack_count, a0 + 2);

        a0 = ack_count;
        r0 = rx_q.size();
        fila.push_back(8'hF0);
        present();
        wait_ack(5);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk("rst_mid_ack",   link.ack_out,   1'b0);
        chk("rst_mid_write", link.write_out, 1'b0);
        chk("rst_mid_data",  link.data_out,  1'b0);
        chk("rst_mid_busy",  link.busy_out,  1'b0);
        reset = 1'b0;
        tick();
        fila.push_back(8'h0F);
        present();
        wait_ack(5);
        wait_idle(40);
        chk("rst_acks",    ack_count, a0 + 2);
        chk("rst_rx_cnt",  rx_q.size(), r0 + 1);
        chk("rst_rx_word", last_rx, 8'h0F);

        fila.push_back(8'h00);
        fila.push_back(8'h81);
        fila.push_back(8'hFF);
        present();
        wait_idle(80);
        chk("loop_00", rx_q[rx_q.size()-3], 8'h00);
        chk("loop_81", rx_q[rx_q.size()-2], 8'h81);
        chk("loop_ff", rx_q[rx_q.size()-1], 8'hFF);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3) == 0 && fila.size() < 4) fila.push_back(W'($urandom));
            link.hold_in = ($urandom_range(4) == 0);
            reset = ($urandom_range(96) == 0);
            present();
            tick();
        end
        reset = 1'b0;
        link.hold_in = 1'b0;
        present();
        wait_idle(200);

        chk("stream_count", rx_q.size(), model_done.size());
        for (int i = 0; i < rx_q.size() && i < model_done.size(); i++)
            chk("stream_word", rx_q[i], model_done[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout expected=test completion");
        $fatal(1, "watchdog expired");
    end
endmodule
